alu_result_rx: RTL and testbench

- Receiving end of the ALU output push/stop interface: accepts {cout, z} results when pushout is high and stopin is low.
- Buffers results in a small FIFO and applies backpressure on stopin.
- Presents results to the host/checker side on a valid/ready read port.
- Keeps result and carry counters, and flags sender hold-rule violations.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_res_fifo.sv | 61 ++++++
 rtl/alu_result_rx.sv | 126 ++++++++++++
 tb/tb_alu_result_rx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types for the ALU result receiver
package alu_pkg;

  localparam int ALU_W = 8;

  typedef struct packed {
    logic             cout;
    logic [ALU_W-1:0] z;
  } alu_res_t;

  typedef enum logic {
    IDLE,
    STALLED
  } hold_state_t;

endpackage

// File: rtl/alu_res_fifo.sv
// rtl/alu_res_fifo.sv - synchronous FIFO of ALU results with count
module alu_res_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  alu_res_t wr_data,
  input  logic     pop,
  output alu_res_t head,
  output logic     full,
  output logic     empty,
  output logic [AW:0] count
);

  alu_res_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Head reads as zero when empty so stale storage never leaks out after reset.
  assign head = empty ? '0 : mem[rd_ptr];

  // Storage array: written on accepted pushes only, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally; count tracks push/pop balance.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_rx.sv
// rtl/alu_result_rx.sv - ALU result receiver with backpressure, stats and hold checker
module alu_result_rx
  import alu_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int STOP_LVL = DEPTH,
  parameter int CNT_W    = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pushout,
  input  logic             cout,
  input  logic [ALU_W-1:0] z,
  output logic             stopin,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [ALU_W-1:0] rd_z,
  output logic             rd_cout,
  output logic [CNT_W-1:0] res_cnt,
  output logic [CNT_W-1:0] carry_cnt,
  output logic             proto_err,
  output logic [AW:0]      occupancy
);

  alu_res_t    in_res;
  alu_res_t    head;
  alu_res_t    cap;
  logic        full;
  logic        empty;
  logic        do_push;
  logic        do_pop;
  logic [AW:0] next_occ;
  hold_state_t state;
  hold_state_t state_n;
  logic        cap_ld;
  logic        err_set;

  assign in_res   = '{cout: cout, z: z};
  assign do_push  = pushout & ~stopin & ~full;
  assign do_pop   = rd_valid & rd_ready;
  assign rd_valid = ~empty;
  assign rd_z     = head.z;
  assign rd_cout  = head.cout;

  alu_res_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (do_push),
    .wr_data (in_res),
    .pop     (do_pop),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .count   (occupancy)
  );

  // Occupancy after this cycle's transfers, used to pre-load the stop register.
  always_comb begin
    next_occ = occupancy;
    case ({do_push, do_pop})
      2'b10:   next_occ = occupancy + (AW+1)'(1);
      2'b01:   next_occ = occupancy - (AW+1)'(1);
      default: next_occ = occupancy;
    endcase
  end

  // Backpressure register and result/carry statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      stopin    <= 1'b0;
      res_cnt   <= '0;
      carry_cnt <= '0;
    end else begin
      stopin <= (next_occ >= (AW+1)'(STOP_LVL));
      if (do_push) begin
        res_cnt   <= res_cnt + CNT_W'(1);
        carry_cnt <= carry_cnt + CNT_W'(cout);
      end
    end
  end

  // Hold checker state, captured stalled data and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cap       <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_n;
      if (cap_ld) begin
        cap <= in_res;
      end
      if (err_set) begin
        proto_err <= 1'b1;
      end
    end
  end

  // Hold checker next state: data must stay put while stalled, and pushout must not drop.
  always_comb begin
    state_n = state;
    cap_ld  = 1'b0;
    err_set = 1'b0;
    case (state)
      IDLE: begin
        if (pushout && stopin) begin
          cap_ld  = 1'b1;
          state_n = STALLED;
        end
      end
      STALLED: begin
        if (!stopin) begin
          state_n = IDLE;
        end else if (!pushout) begin
          err_set = 1'b1;
          state_n = IDLE;
        end else if (in_res != cap) begin
          err_set = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_result_rx.sv
// tb/tb_alu_result_rx.sv - self-checking bench for alu_result_rx
module tb_alu_result_rx;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pushout = 1'b0;
  logic        cout = 1'b0;
  logic [7:0]  z = 8'h00;
  logic        rd_ready = 1'b0;

  logic        stopin, rd_valid, rd_cout, proto_err;
  logic [7:0]  rd_z;
  logic [15:0] res_cnt, carry_cnt;
  logic [3:0]  occupancy;

  logic        stopin4, rd_valid4, rd_cout4, proto_err4;
  logic [7:0]  rd_z4;
  logic [3:0]  res_cnt4, carry_cnt4;
  logic [3:0]  occupancy4;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  logic [8:0] q[$];
  int         m_res = 0;
  int         m_carry = 0;
  logic       m_stop = 1'b0;
  logic       m_err = 1'b0;
  logic       m_stalled = 1'b0;
  logic [8:0] m_cap = '0;

  always #5 clk = ~clk;

  alu_result_rx #(.DEPTH(DEPTH), .STOP_LVL(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .pushout(pushout), .cout(cout), .z(z),
    .stopin(stopin), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_z(rd_z), .rd_cout(rd_cout), .res_cnt(res_cnt), .carry_cnt(carry_cnt),
    .proto_err(proto_err), .occupancy(occupancy)
  );

  alu_result_rx #(.DEPTH(DEPTH), .STOP_LVL(DEPTH), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .pushout(pushout), .cout(cout), .z(z),
    .stopin(stopin4), .rd_valid(rd_valid4), .rd_ready(rd_ready),
    .rd_z(rd_z4), .rd_cout(rd_cout4), .res_cnt(res_cnt4), .carry_cnt(carry_cnt4),
    .proto_err(proto_err4), .occupancy(occupancy4)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int ez, ec;
    ez = (q.size() != 0) ? int'(q[0][7:0]) : 0;
    ec = (q.size() != 0) ? int'(q[0][8]) : 0;
    chk("stopin", int'(stopin), int'(m_stop));
    chk("rd_valid", int'(rd_valid), int'(q.size() != 0));
    chk("rd_z", int'(rd_z), ez);
    chk("rd_cout", int'(rd_cout), ec);
    chk("occupancy", int'(occupancy), q.size());
    chk("res_cnt", int'(res_cnt), m_res % 65536);
    chk("carry_cnt", int'(carry_cnt), m_carry % 65536);
    chk("proto_err", int'(proto_err), int'(m_err));
    chk("res_cnt4", int'(res_cnt4), m_res % 16);
    chk("carry_cnt4", int'(carry_cnt4), m_carry % 16);
  endtask

  // Apply the spec's rules to the model for the current inputs, clock once, compare.
  task automatic step();
    logic xin, xout;
    if (rst) begin
      q.delete();
      m_res = 0; m_carry = 0; m_stop = 1'b0; m_err = 1'b0;
      m_stalled = 1'b0; m_cap = '0;
    end else begin
      xin  = pushout && !m_stop;
      xout = (q.size() != 0) && rd_ready;
      if (!m_stalled) begin
        if (pushout && m_stop) begin
          m_stalled = 1'b1;
          m_cap = {cout, z};
        end
      end else if (m_stop) begin
        if (!pushout) begin
          m_err = 1'b1;
          m_stalled = 1'b0;
        end else if ({cout, z} != m_cap) begin
          m_err = 1'b1;
        end
      end else begin
        m_stalled = 1'b0;
      end
      if (xout) void'(q.pop_front());
      if (xin) begin
        q.push_back({cout, z});
        m_res++;
        if (cout) m_carry++;
      end
      m_stop = (q.size() >= DEPTH);
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic drive(input logic r, input logic p, input logic c,
                       input logic [7:0] d, input logic rr);
    rst = r; pushout = p; cout = c; z = d; rd_ready = rr;
  endtask

  typedef struct {
    logic       rst, pushout, cout;
    logic [7:0] z;
    logic       rd_ready;
    logic       exp_valid;
    logic [7:0] exp_z;
    logic       exp_cout;
    int         exp_occ;
    int         exp_res;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1, 1, 1};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, 8'h5A, 1'b0, 1, 2};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 8'h11, 1'b1, 1, 3};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b1, 1, 3};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 0, 3};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 0, 3};

    drive(1, 0, 0, 8'h00, 0);
    step();
    step();

    // Table: reset, single result, pop, empty-with-ready (no bypass), underflow
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].rst, tbl[i].pushout, tbl[i].cout, tbl[i].z, tbl[i].rd_ready);
      step();
      chk($sformatf("tbl%0d_valid", i), int'(rd_valid), int'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_z", i), int'(rd_z), int'(tbl[i].exp_z));
      chk($sformatf("tbl%0d_cout", i), int'(rd_cout), int'(tbl[i].exp_cout));
      chk($sformatf("tbl%0d_occ", i), int'(occupancy), tbl[i].exp_occ);
      chk($sformatf("tbl%0d_res", i), int'(res_cnt), tbl[i].exp_res);
    end

    // Fill to full, blocked 9th push, pop frees space, drain order
    drive(1, 0, 0, 8'h00, 0); step();
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 1'(i), 8'(i), 0); step();
    end
    chk("full_stopin", int'(stopin), 1);
    chk("full_occ", int'(occupancy), 8);
    drive(0, 1, 0, 8'd8, 0); step();
    chk("blocked_occ", int'(occupancy), 8);
    chk("blocked_res", int'(res_cnt), 8);
    chk("head_before_pop", int'(rd_z), 0);
    drive(0, 1, 0, 8'd8, 1); step();
    chk("pop_stopin", int'(stopin), 0);
    drive(0, 1, 0, 8'd8, 0); step();
    chk("ninth_res", int'(res_cnt), 9);
    chk("ninth_occ", int'(occupancy), 8);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain%0d", i), int'(rd_z), i);
      drive(0, 0, 0, 8'h00, 1); step();
    end
    chk("drain_empty", int'(rd_valid), 0);
    chk("fill_proto_err", int'(proto_err), 0);

    // Streaming 100 cycles
    drive(1, 0, 0, 8'h00, 0); step();
    for (int i = 0; i < 100; i++) begin
      drive(0, 1, 1'(i % 3 == 0), 8'(i), 1); step();
      chk("stream_occ", int'(occupancy), 1);
      chk("stream_stop", int'(stopin), 0);
      chk("stream_head", int'(rd_z), i % 256);
    end
    chk("stream_res", int'(res_cnt), 100);
    drive(0, 0, 0, 8'h00, 1); step();

    // Hold violation: change data while stalled
    drive(1, 0, 0, 8'h00, 0); step();
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 8'(i), 0); step();
    end
    drive(0, 1, 0, 8'h3C, 0); step();
    chk("hold_ok", int'(proto_err), 0);
    drive(0, 1, 0, 8'h3D, 0); step();
    chk("hold_err", int'(proto_err), 1);
    for (int i = 0; i < 9; i++) begin
      drive(0, 0, 0, 8'h00, 1); step();
    end
    chk("hold_err_sticky", int'(proto_err), 1);
    chk("hold_drained", int'(occupancy), 0);
    drive(1, 0, 0, 8'h00, 0); step();
    chk("hold_err_cleared", int'(proto_err), 0);

    // Counter wrap on the 4-bit instance
    drive(0, 0, 0, 8'h00, 0); step();
    for (int i = 0; i < 17; i++) begin
      drive(0, 1, 1, 8'(i + 40), 1); step();
    end
    chk("wrap_res4", int'(res_cnt4), 1);
    chk("wrap_carry4", int'(carry_cnt4), 1);
    chk("wrap_res16", int'(res_cnt), 17);
    drive(0, 0, 0, 8'h00, 1); step();

    // Reset mid-operation with a push in the reset cycle
    drive(1, 0, 0, 8'h00, 0); step();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 8'(i + 100), 0); step();
    end
    chk("mid_stop", int'(stopin), 0);
    chk("mid_occ5", int'(occupancy), 5);
    drive(1, 1, 1, 8'hEE, 0); step();
    chk("mid_valid", int'(rd_valid), 0);
    chk("mid_occ", int'(occupancy), 0);
    chk("mid_res", int'(res_cnt), 0);
    chk("mid_carry", int'(carry_cnt), 0);
    drive(0, 1, 0, 8'h77, 0); step();
    chk("mid_after_z", int'(rd_z), 8'h77);
    chk("mid_after_valid", int'(rd_valid), 1);

    // Randomized traffic, mostly rule-abiding sender with rare glitches and resets
    drive(1, 0, 0, 8'h00, 0); step();
    for (int i = 0; i < 600; i++) begin
      logic hold;
      hold = pushout && m_stop;
      if (hold && ($urandom_range(0, 59) != 0)) begin
        drive(0, 1, cout, z, 1'($urandom_range(0, 2) == 0));
      end else begin
        drive(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 2) != 0),
              1'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0));
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
